// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// master = pipeline side (drives hazard inputs), slave = hazard control unit.
interface hazard_control_unit_if;
   logic        ID_ExMemRead;
   logic        ID_ExRegWrite;
   logic [4:0]  ID_ExRegisterRd;
   logic        Ex_MemMemRead;
   logic [4:0]  Ex_MemRegisterRd;
   logic [4:0]  IF_IdRegisterRs;
   logic [4:0]  IF_IdRegisterRt;
   logic        IF_IdUsesRt;
   logic        IF_IdBranch;
   logic        IF_IdJump;
   logic        branchTaken;
   logic        memReady;
   logic        pcWrite;
   logic        IF_IdWrite;
   logic        ID_ExBubble;
   logic        IF_IdFlush;
   logic        pipeFreeze;
   logic [1:0]  ctrlState;
   logic [15:0] stallCount;

   modport master (
      output ID_ExMemRead, ID_ExRegWrite, ID_ExRegisterRd, Ex_MemMemRead, Ex_MemRegisterRd,
             IF_IdRegisterRs, IF_IdRegisterRt, IF_IdUsesRt, IF_IdBranch, IF_IdJump,
             branchTaken, memReady,
      input  pcWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, pipeFreeze, ctrlState, stallCount
   );

   modport slave (
      input  ID_ExMemRead, ID_ExRegWrite, ID_ExRegisterRd, Ex_MemMemRead, Ex_MemRegisterRd,
             IF_IdRegisterRs, IF_IdRegisterRt, IF_IdUsesRt, IF_IdBranch, IF_IdJump,
             branchTaken, memReady,
      output pcWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, pipeFreeze, ctrlState, stallCount
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and branch-operand stalls, memory-wait freeze,
// control-transfer flushes, plus a saturating stall-cycle counter.
module hazard_control_unit (
   input  logic                  clk,
   input  logic                  reset,
   hazard_control_unit_if.slave  hazardBus
);
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      BR_WAIT  = 2'b01,
      MEM_WAIT = 2'b10
   } ctrlState_t;

   ctrlState_t  stateReg, stateNext;
   ctrlState_t  retStateReg, retStateNext;
   logic [15:0] stallCountReg;

   logic [4:0] destReg [2];
   logic [1:0] srcHit;
   logic       loadUse, brAlu, brLoad2, brLoad1;
   logic       pcWr, ifIdWr, bubble, flush, freeze;

   assign destReg[0] = hazardBus.ID_ExRegisterRd;
   assign destReg[1] = hazardBus.Ex_MemRegisterRd;

   // srcHit[0]: ID/EX destination, srcHit[1]: EX/MEM destination; r0 never matches
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : genSrcHit
         logic rsMatch, rtMatch;
         assign rsMatch = (destReg[gi] != 5'd0) && (destReg[gi] == hazardBus.IF_IdRegisterRs);
         assign rtMatch = (destReg[gi] != 5'd0) && (destReg[gi] == hazardBus.IF_IdRegisterRt);
         assign srcHit[gi] = rsMatch || (hazardBus.IF_IdUsesRt && rtMatch);
      end
   endgenerate

   assign loadUse = hazardBus.ID_ExMemRead && srcHit[0];
   assign brAlu   = hazardBus.IF_IdBranch && hazardBus.ID_ExRegWrite &&
                    !hazardBus.ID_ExMemRead && srcHit[0];
   assign brLoad2 = hazardBus.IF_IdBranch && hazardBus.ID_ExMemRead && srcHit[0];
   assign brLoad1 = hazardBus.IF_IdBranch && hazardBus.Ex_MemMemRead && srcHit[1];

   always_comb begin
      stateNext    = stateReg;
      retStateNext = retStateReg;
      pcWr         = 1'b1;
      ifIdWr       = 1'b1;
      bubble       = 1'b0;
      flush        = 1'b0;
      freeze       = 1'b0;
      if (reset) begin
         pcWr         = 1'b0;
         ifIdWr       = 1'b0;
         bubble       = 1'b1;
         flush        = 1'b1;
         stateNext    = RUN;
         retStateNext = RUN;
      end else begin
         case (stateReg)
            RUN: begin
               if (!hazardBus.memReady) begin
                  pcWr         = 1'b0;
                  ifIdWr       = 1'b0;
                  freeze       = 1'b1;
                  retStateNext = RUN;
                  stateNext    = MEM_WAIT;
               end else if (brLoad2) begin
                  pcWr      = 1'b0;
                  ifIdWr    = 1'b0;
                  bubble    = 1'b1;
                  stateNext = BR_WAIT;
               end else if (brAlu || brLoad1 || loadUse) begin
                  pcWr   = 1'b0;
                  ifIdWr = 1'b0;
                  bubble = 1'b1;
               end else begin
                  // branchTaken is only trusted once no operand hazard is pending
                  flush = hazardBus.IF_IdJump ||
                          (hazardBus.IF_IdBranch && hazardBus.branchTaken);
               end
            end
            BR_WAIT: begin
               pcWr   = 1'b0;
               ifIdWr = 1'b0;
               if (!hazardBus.memReady) begin
                  freeze       = 1'b1;
                  retStateNext = BR_WAIT;
                  stateNext    = MEM_WAIT;
               end else begin
                  bubble    = 1'b1;
                  stateNext = RUN;
               end
            end
            MEM_WAIT: begin
               pcWr   = 1'b0;
               ifIdWr = 1'b0;
               freeze = 1'b1;
               if (hazardBus.memReady) begin
                  stateNext = retStateReg;
               end
            end
            default: begin
               pcWr      = 1'b0;
               ifIdWr    = 1'b0;
               bubble    = 1'b1;
               stateNext = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg      <= RUN;
         retStateReg   <= RUN;
         stallCountReg <= 16'd0;
      end else begin
         stateReg    <= stateNext;
         retStateReg <= retStateNext;
         if (!pcWr && (stallCountReg != 16'hFFFF)) begin
            stallCountReg <= stallCountReg + 16'd1;
         end
      end
   end

   assign hazardBus.pcWrite     = pcWr;
   assign hazardBus.IF_IdWrite  = ifIdWr;
   assign hazardBus.ID_ExBubble = bubble;
   assign hazardBus.IF_IdFlush  = flush;
   assign hazardBus.pipeFreeze  = freeze;
   assign hazardBus.ctrlState   = stateReg;
   assign hazardBus.stallCount  = stallCountReg;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios plus random traffic,
// predicted by a pending-stall / memory-wait reference model.
module tb_hazard_control_unit;
   typedef struct packed {
      logic       rst;
      logic       memRead;
      logic       regWrite;
      logic [4:0] exRd;
      logic       exMemRead;
      logic [4:0] exMemRd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic       branch;
      logic       jump;
      logic       taken;
      logic       memReady;
   } stim_t;

   typedef struct packed {
      int          id;
      logic [4:0]  outs;   // {pcWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, pipeFreeze}
      logic [1:0]  st;
      logic [15:0] cnt;
   } exp_t;

   localparam logic [4:0] OUT_STALL  = 5'b00100;
   localparam logic [4:0] OUT_FREEZE = 5'b00001;
   localparam logic [4:0] OUT_RESET  = 5'b00110;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hazard_control_unit_if hif ();

   hazard_control_unit dut (
      .clk       (clk),
      .reset     (reset),
      .hazardBus (hif)
   );

   exp_t scoreQ [$];
   int   checks = 0;
   int   errors = 0;
   int   txnId  = 0;

   // Reference model: an owed extra stall (load feeding a branch) and a memory-wait flag
   bit   modelPending = 0;
   bit   modelMemWait = 0;
   int   modelCount   = 0;

   function automatic bit srcHit(input logic [4:0] r, input stim_t s);
      return (r != 5'd0) && ((r == s.rs) || (s.usesRt && (r == s.rt)));
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.memReady = 1'b1;
      return s;
   endfunction

   task automatic applyCycle(input stim_t s);
      exp_t e;
      bit   brLoad2, otherHaz;
      @(posedge clk);
      #1;
      reset                = s.rst;
      hif.ID_ExMemRead     = s.memRead;
      hif.ID_ExRegWrite    = s.regWrite;
      hif.ID_ExRegisterRd  = s.exRd;
      hif.Ex_MemMemRead    = s.exMemRead;
      hif.Ex_MemRegisterRd = s.exMemRd;
      hif.IF_IdRegisterRs  = s.rs;
      hif.IF_IdRegisterRt  = s.rt;
      hif.IF_IdUsesRt      = s.usesRt;
      hif.IF_IdBranch      = s.branch;
      hif.IF_IdJump        = s.jump;
      hif.branchTaken      = s.taken;
      hif.memReady         = s.memReady;

      brLoad2  = s.branch && s.memRead && srcHit(s.exRd, s);
      otherHaz = (s.memRead && srcHit(s.exRd, s)) ||
                 (s.branch && s.regWrite && !s.memRead && srcHit(s.exRd, s)) ||
                 (s.branch && s.exMemRead && srcHit(s.exMemRd, s));

      e.id  = txnId;
      e.st  = modelMemWait ? 2'd2 : (modelPending ? 2'd1 : 2'd0);
      e.cnt = 16'(modelCount);
      if (s.rst) begin
         e.outs       = OUT_RESET;
         modelPending = 0;
         modelMemWait = 0;
         modelCount   = 0;
      end else begin
         if (modelMemWait) begin
            e.outs = OUT_FREEZE;
            if (s.memReady) modelMemWait = 0;
         end else if (!s.memReady) begin
            e.outs       = OUT_FREEZE;
            modelMemWait = 1;
         end else if (modelPending) begin
            e.outs       = OUT_STALL;
            modelPending = 0;
         end else if (brLoad2) begin
            e.outs       = OUT_STALL;
            modelPending = 1;
         end else if (otherHaz) begin
            e.outs = OUT_STALL;
         end else begin
            e.outs = {1'b1, 1'b1, 1'b0, s.jump || (s.branch && s.taken), 1'b0};
         end
         if (!e.outs[4] && modelCount < 65535) modelCount++;
      end
      scoreQ.push_back(e);
      txnId++;
   endtask

   // Monitor: every cycle the DUT presents a response, compare it with the oldest prediction
   initial begin
      exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (scoreQ.size() > 0) begin
            e   = scoreQ.pop_front();
            act = {hif.pcWrite, hif.IF_IdWrite, hif.ID_ExBubble, hif.IF_IdFlush, hif.pipeFreeze};
            checks++;
            if (act !== e.outs) begin
               errors++;
               $display("FAIL outputs txn %0d: got %b expected %b", e.id, act, e.outs);
            end
            checks++;
            if (hif.ctrlState !== e.st) begin
               errors++;
               $display("FAIL ctrlState txn %0d: got %0d expected %0d", e.id, hif.ctrlState, e.st);
            end
            checks++;
            if (hif.stallCount !== e.cnt) begin
               errors++;
               $display("FAIL stallCount txn %0d: got %0d expected %0d", e.id, hif.stallCount, e.cnt);
            end
         end
      end
   end

   initial begin
      stim_t s;
      int    waitCycles;
      s = idle();
      reset                = 1'b1;
      hif.ID_ExMemRead     = 1'b0;
      hif.ID_ExRegWrite    = 1'b0;
      hif.ID_ExRegisterRd  = 5'd0;
      hif.Ex_MemMemRead    = 1'b0;
      hif.Ex_MemRegisterRd = 5'd0;
      hif.IF_IdRegisterRs  = 5'd0;
      hif.IF_IdRegisterRt  = 5'd0;
      hif.IF_IdUsesRt      = 1'b0;
      hif.IF_IdBranch      = 1'b0;
      hif.IF_IdJump        = 1'b0;
      hif.branchTaken      = 1'b0;
      hif.memReady         = 1'b1;
      repeat (2) @(posedge clk);

      // Reset state
      s = idle(); s.rst = 1; applyCycle(s);
      s = idle(); applyCycle(s);

      // Load-use on Rs=5, then a normal cycle
      s = idle(); s.memRead = 1; s.exRd = 5; s.rs = 5; applyCycle(s);
      s = idle(); s.rs = 5; applyCycle(s);

      // Zero register never hazards; Rt ignored unless used
      s = idle(); s.memRead = 1; s.exRd = 0; s.rs = 0; applyCycle(s);
      s = idle(); s.memRead = 1; s.exRd = 9; s.rt = 9; applyCycle(s);
      s = idle(); s.memRead = 1; s.exRd = 9; s.rt = 9; s.usesRt = 1; applyCycle(s);

      // Branch after load: two stalls with branchTaken ignored, then the flush
      s = idle(); s.branch = 1; s.rs = 7; s.memRead = 1; s.exRd = 7; s.taken = 1; applyCycle(s);
      s = idle(); s.branch = 1; s.rs = 7; s.exMemRead = 1; s.exMemRd = 7; s.taken = 1; applyCycle(s);
      s = idle(); s.branch = 1; s.rs = 7; s.taken = 1; applyCycle(s);
      s = idle(); applyCycle(s);

      // Branch after ALU op: one stall
      s = idle(); s.branch = 1; s.rs = 3; s.regWrite = 1; s.exRd = 3; applyCycle(s);

      // Memory wait inside BR_WAIT
      s = idle(); s.branch = 1; s.rs = 4; s.memRead = 1; s.exRd = 4; applyCycle(s);
      s = idle(); s.memReady = 0;
      repeat (3) applyCycle(s);
      s = idle();
      repeat (3) applyCycle(s);

      // Jump with no hazard
      s = idle(); s.jump = 1; applyCycle(s);

      // Reset while in MEM_WAIT
      s = idle(); s.memReady = 0; applyCycle(s); applyCycle(s);
      s.rst = 1; applyCycle(s);
      s = idle(); applyCycle(s);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         s.rst       = ($urandom % 64) == 0;
         s.memRead   = $urandom % 2;
         s.regWrite  = $urandom % 2;
         s.exRd      = 5'($urandom_range(0, 7));
         s.exMemRead = $urandom % 2;
         s.exMemRd   = 5'($urandom_range(0, 7));
         s.rs        = 5'($urandom_range(0, 7));
         s.rt        = 5'($urandom_range(0, 7));
         s.usesRt    = $urandom % 2;
         s.branch    = ($urandom % 3) == 0;
         s.jump      = ($urandom % 8) == 0;
         s.taken     = $urandom % 2;
         s.memReady  = ($urandom % 8) != 0;
         applyCycle(s);
      end

      // Saturation: a long memory wait drives the counter to its ceiling
      s = idle(); s.rst = 1; applyCycle(s);
      s = idle(); s.memReady = 0;
      repeat (65540) applyCycle(s);
      s = idle(); applyCycle(s); applyCycle(s);
      s.rst = 1; applyCycle(s);
      s = idle(); applyCycle(s); applyCycle(s);

      waitCycles = 0;
      while (scoreQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      if (scoreQ.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d predictions left, required 0", scoreQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
